// File: rtl/recirculador_pkg.sv
// Shared types and helpers for the recirculador_param block.
package recirculador_pkg;

   typedef enum logic [1:0] {
      PASS   = 2'd0,
      DIVERT = 2'd1,
      REPLAY = 2'd2
   } recirc_state_t;

   // Width of a per-lane occupancy count able to hold 0..depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/recirc_lane_fifo.sv
// Per-lane synchronous FIFO (DEPTH x DATA_W) with show-ahead head word.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module recirc_lane_fifo
   import recirculador_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         din,
   output logic [DATA_W-1:0]         dout,
   output logic                      empty,
   output logic                      full,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count_q;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];
   assign count   = count_q;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/recirculador_param.sv
// Parametrised recirculator: routes lane words to the active path while the
// link is up, diverts (and stores) them while it is down, and replays the
// stored words in order once the link returns.
// Optional macro RECIRC_OCCUPANCY_EN adds the per-lane occupancy output.
//
// state  | meaning
// PASS   | link up, FIFOs empty, live words go straight to the active path
// DIVERT | link down, live words to deactivated path and copied into FIFOs
// REPLAY | link up, FIFO heads drained to active path ahead of live words
//
// The routing for a cycle is chosen from the registered state together with
// this cycle's up sample, so a transition takes effect on the same edge that
// samples it; replaying reflects the state register.
module recirculador_param
   import recirculador_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [LANES*DATA_W-1:0]   data_in,
   input  logic [LANES-1:0]          valid_in,
   input  logic                      idle,
   input  logic                      active,
   output logic [LANES*DATA_W-1:0]   data_activo,
   output logic [LANES-1:0]          valid_activo,
   output logic [LANES*DATA_W-1:0]   data_desactivado,
   output logic [LANES-1:0]          valid_desactivado,
   output logic                      replaying,
   output logic [LANES-1:0]          overflow
`ifdef RECIRC_OCCUPANCY_EN
   ,
   output logic [LANES*cnt_w(DEPTH)-1:0] occupancy
`endif
);

   localparam int CW = cnt_w(DEPTH);

   recirc_state_t state_q, state_d, mode;

   logic                    up;
   logic                    any_stored;
   logic [LANES-1:0]        push, pop, fifo_empty, fifo_full, lane_drained;
   logic [DATA_W-1:0]       fifo_dout  [LANES];
   logic [CW-1:0]           fifo_count [LANES];
   logic [LANES*DATA_W-1:0] act_d, dea_d;
   logic [LANES-1:0]        act_v, dea_v;

   assign up         = idle & active;
   assign any_stored = ~(&fifo_empty);
   assign replaying  = (state_q == REPLAY);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      recirc_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   (data_in[g*DATA_W +: DATA_W]),
         .dout  (fifo_dout[g]),
         .empty (fifo_empty[g]),
         .full  (fifo_full[g]),
         .count (fifo_count[g])
      );
`ifdef RECIRC_OCCUPANCY_EN
      assign occupancy[g*CW +: CW] = fifo_count[g];
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= DIVERT;
      else       state_q <= state_d;
   end

   // Per-cycle routing mode, lane data steering and next state.
   always_comb begin
      mode         = DIVERT;
      act_v        = '0;
      act_d        = '0;
      dea_v        = '0;
      dea_d        = '0;
      push         = '0;
      pop          = '0;
      lane_drained = fifo_empty;
      if (up) begin
         case (state_q)
            PASS:    mode = PASS;
            DIVERT:  mode = any_stored ? REPLAY : PASS;
            REPLAY:  mode = REPLAY;
            default: mode = PASS;
         endcase
      end
      for (int i = 0; i < LANES; i++) begin
         case (mode)
            PASS: begin
               act_v[i] = valid_in[i];
               act_d[i*DATA_W +: DATA_W] = valid_in[i] ? data_in[i*DATA_W +: DATA_W] : '0;
            end
            REPLAY: begin
               if (!fifo_empty[i]) begin
                  pop[i]          = 1'b1;
                  push[i]         = valid_in[i];
                  act_v[i]        = 1'b1;
                  act_d[i*DATA_W +: DATA_W] = fifo_dout[i];
                  lane_drained[i] = (fifo_count[i] == CW'(1)) && !valid_in[i];
               end else begin
                  act_v[i] = valid_in[i];
                  act_d[i*DATA_W +: DATA_W] = valid_in[i] ? data_in[i*DATA_W +: DATA_W] : '0;
               end
            end
            default: begin
               dea_v[i] = valid_in[i];
               dea_d[i*DATA_W +: DATA_W] = valid_in[i] ? data_in[i*DATA_W +: DATA_W] : '0;
               push[i]  = valid_in[i];
            end
         endcase
      end
      state_d = ((mode == REPLAY) && (&lane_drained)) ? PASS : mode;
   end

   // Registered outputs and sticky overflow flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_activo       <= '0;
         valid_activo      <= '0;
         data_desactivado  <= '0;
         valid_desactivado <= '0;
         overflow          <= '0;
      end else begin
         data_activo       <= act_d;
         valid_activo      <= act_v;
         data_desactivado  <= dea_d;
         valid_desactivado <= dea_v;
         overflow          <= overflow | (push & fifo_full & ~pop);
      end
   end

endmodule

// File: doc/recirculador_param.md
Name: recirculador_param

Overview:
- Parametrised recirculator: LANES lanes of DATA_W-bit words with per-lane valid.
- Routes live words to the active path (toward mux L1) when the link is up (idle & active); otherwise routes them to the deactivated path (toward the probador).
- While the link is down, each lane also holds a copy of its diverted words in a FIFO. When the link comes back up, the block replays the stored words in order on the active path before, or interleaved ahead of, new live data.

Parameters:
- LANES, 4, number of lanes.
- DATA_W, 8, bits per lane word.
- DEPTH, 4, per-lane recirculation FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- valid_in  in  LANES  per-lane valid.
- idle  in  1  idle indication from the serial-to-parallel block.
- active  in  1  link active.
- data_activo  out  LANES*DATA_W  active-path data.
- valid_activo  out  LANES  active-path valid.
- data_desactivado  out  LANES*DATA_W  deactivated-path data.
- valid_desactivado  out  LANES  deactivated-path valid.
- replaying  out  1  high while the FSM is in REPLAY.
- overflow  out  LANES  sticky per-lane FIFO overflow flag.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - All outputs 0, FIFOs emptied, FSM = DIVERT.
  - Reset mid-operation discards all stored words.
- Link-up condition: up = idle & active, sampled each rising edge.
- All outputs are registered, with 1-cycle latency from inputs.
- FSM states: PASS, DIVERT, REPLAY.
  - DIVERT -> REPLAY when up and any FIFO is non-empty.
  - DIVERT -> PASS when up and all FIFOs are empty.
  - PASS -> DIVERT when !up.
  - REPLAY -> DIVERT when !up. FIFO contents are retained.
  - REPLAY -> PASS when up and every FIFO is empty after this cycle's push/pop.
- PASS, per lane:
  - valid_activo = valid_in and data_activo = data_in.
  - valid_desactivado = 0.
- DIVERT, per lane:
  - valid_desactivado = valid_in and data_desactivado = data_in.
  - Also push data_in into the lane FIFO when valid.
  - valid_activo = 0.
- REPLAY, per lane:
  - If the FIFO is non-empty: pop the head to the active path (valid_activo = 1); push live data_in when valid.
  - If the FIFO is empty: a live valid word bypasses directly to the active path.
  - Per-lane order is strictly preserved.
  - valid_desactivado = 0.
- Lanes are independent in data movement. Only FSM transitions are global.
- A continuous live stream during REPLAY keeps occupancy constant. The FSM stays in REPLAY until all FIFOs drain; this is intended.
- FIFO full:
  - A push with no simultaneous pop drops the incoming word and sets overflow[i]. overflow[i] clears only on reset.
  - Push and pop together when full is legal; occupancy is unchanged.
- Data outputs are zeroed when the matching valid is 0.

Optional Feature:
- Macro: RECIRC_OCCUPANCY_EN.
- Defined: adds output occupancy (LANES*($clog2(DEPTH)+1) bits), the per-lane FIFO count, registered and 0 on reset.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package recirculador_pkg holds:
  - the FSM state enum (PASS = 2'd0, DIVERT = 2'd1, REPLAY = 2'd2);
  - a localparam helper for count width, $clog2(DEPTH)+1.
- Sub-module recirc_lane_fifo:
  - one DEPTH x DATA_W synchronous FIFO per lane;
  - ports: push, pop, din, dout, empty, full, count;
  - instantiated LANES times with a generate loop.

Test Plan:
- Reset then idle=1, active=1, lane words 0x00/0x0E/0x0E/0x4E, all valid -> next cycle valid_activo=4'hF with the same data; valid_desactivado=0; FSM PASS.
- idle=0, active=0; two cycles of words 0xC0/0x8E/0x8E/0x0A then 0xC4/0x9E/0x8E/0x0A, all valid -> both words appear on the deactivated path; FIFO count = 2 per lane.
- Then up=1 with valid_in=0 -> replaying=1; active path emits 0xC0… then 0xC4… on consecutive cycles; PASS entered after the second pop.
- In DIVERT, push DEPTH+1 valid words on lane 0 only -> overflow = 4'b0001 stays set; replay yields exactly DEPTH words, the extra one dropped.
- REPLAY with continuous live valid words -> output order is stored words then live words with no gaps; replaying stays 1 until up drops.
- Assert reset mid-REPLAY with non-empty FIFOs -> all outputs 0 immediately; after release, up=1 gives PASS with no replayed words.
